// File: rtl/tsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsp_pkg
// Description : Shared types and constants for the TSP city loader slice.
// Revision    : 1.0 - initial release
// ============================================================================
package tsp_pkg;

  localparam int C_COORD_WIDTH = 32;
  localparam int C_MAX_CITIES  = 128;
  localparam int C_CNT_WIDTH   = 8;

  // Loader control states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SIGNAL = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // One city as packed in a FIFO word: X in the low half, Y in the high half
  typedef struct packed {
    logic [C_COORD_WIDTH-1:0] y;
    logic [C_COORD_WIDTH-1:0] x;
  } city_t;

endpackage
`default_nettype wire

// File: rtl/tsp_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tsp_bbox_tracker
// Description : Running unsigned bounding box of the cities written by the
//               loader. Re-initialised on every accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module tsp_bbox_tracker
  import tsp_pkg::*;
(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     init,
  input  logic                     update,
  input  city_t                    city,
  output logic [C_COORD_WIDTH-1:0] min_x,
  output logic [C_COORD_WIDTH-1:0] max_x,
  output logic [C_COORD_WIDTH-1:0] min_y,
  output logic [C_COORD_WIDTH-1:0] max_y
);

  // Track per-axis extremes; init seeds minima high and maxima low
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      min_x <= '0;
      max_x <= '0;
      min_y <= '0;
      max_y <= '0;
    end else if (init) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
    end else if (update) begin
      if (city.x < min_x) min_x <= city.x;
      if (city.x > max_x) max_x <= city.x;
      if (city.y < min_y) min_y <= city.y;
      if (city.y > max_y) max_y <= city.y;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tsp_city_loader.sv
`default_nettype none
// ============================================================================
// Module      : tsp_city_loader
// Description : Pops city words from the read stage's FWFT FIFO, writes X/Y
//               into the city RAM, signals load_done, then drains padding
//               words until the read stage reports odone.
//               Optional macro TSP_LOADER_BBOX_EN adds min/max coordinate
//               outputs via tsp_bbox_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tsp_city_loader #(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_COORD_WIDTH = tsp_pkg::C_COORD_WIDTH,
  parameter int C_MAX_CITIES  = tsp_pkg::C_MAX_CITIES,
  parameter int C_CNT_WIDTH   = tsp_pkg::C_CNT_WIDTH
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            start,
  input  logic [C_CNT_WIDTH-1:0]          num_cities,
  output logic                            rd_en,
  input  logic [C_DATA_WIDTH-1:0]         rd_data,
  input  logic                            rd_tvalid_n,
  input  logic                            src_odone,
  output logic                            load_done,
  output logic                            mem_we,
  output logic [$clog2(C_MAX_CITIES)-1:0] mem_addr,
  output logic [C_COORD_WIDTH-1:0]        mem_wx,
  output logic [C_COORD_WIDTH-1:0]        mem_wy,
  output logic [C_CNT_WIDTH-1:0]          city_count,
  output logic                            busy,
  output logic                            done,
  output logic                            err
`ifdef TSP_LOADER_BBOX_EN
  ,
  output logic [C_COORD_WIDTH-1:0]        min_x,
  output logic [C_COORD_WIDTH-1:0]        max_x,
  output logic [C_COORD_WIDTH-1:0]        min_y,
  output logic [C_COORD_WIDTH-1:0]        max_y
`endif
);

  import tsp_pkg::*;

  localparam int C_ADDR_WIDTH = $clog2(C_MAX_CITIES);
  // One extra bit so a target of exactly C_MAX_CITIES never wraps
  localparam logic [C_CNT_WIDTH:0] C_MAX_EXT = (C_CNT_WIDTH+1)'(C_MAX_CITIES);

  state_t                 r_state;
  logic [C_CNT_WIDTH:0]   r_target;

  logic                   w_start_ok;
  logic                   w_zero;
  logic                   w_bad;
  logic [C_CNT_WIDTH:0]   w_num_ext;
  logic [C_CNT_WIDTH:0]   w_target;
  logic [C_CNT_WIDTH:0]   w_count_inc;

  assign rd_en       = ~rd_tvalid_n & ((r_state == LOAD) | (r_state == DRAIN));
  assign w_start_ok  = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_num_ext   = {1'b0, num_cities};
  assign w_zero      = (num_cities == '0);
  assign w_bad       = w_zero | (w_num_ext > C_MAX_EXT);
  assign w_target    = (w_num_ext > C_MAX_EXT) ? C_MAX_EXT : w_num_ext;
  assign w_count_inc = {1'b0, city_count} + (C_CNT_WIDTH+1)'(1);

  // Control FSM with registered RAM write port and status outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_target   <= '0;
      city_count <= '0;
      load_done  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wx     <= '0;
      mem_wy     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_target   <= w_target;
            city_count <= '0;
            err        <= w_bad;
            busy       <= 1'b1;
            // A zero-city request has nothing to load; report straight away
            load_done  <= w_zero;
            r_state    <= w_zero ? SIGNAL : LOAD;
          end
        end
        LOAD: begin
          if (rd_en) begin
            mem_we     <= 1'b1;
            mem_addr   <= city_count[C_ADDR_WIDTH-1:0];
            mem_wx     <= rd_data[C_COORD_WIDTH-1:0];
            mem_wy     <= rd_data[C_DATA_WIDTH-1:C_COORD_WIDTH];
            city_count <= w_count_inc[C_CNT_WIDTH-1:0];
            if (w_count_inc == r_target) begin
              load_done <= 1'b1;
              r_state   <= SIGNAL;
            end
          end
        end
        SIGNAL: begin
          r_state <= DRAIN;
        end
        DRAIN: begin
          // Padding pops are consumed by rd_en alone and never reach the RAM
          if (src_odone) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef TSP_LOADER_BBOX_EN
  city_t w_city;

  assign w_city.x = rd_data[C_COORD_WIDTH-1:0];
  assign w_city.y = rd_data[C_DATA_WIDTH-1:C_COORD_WIDTH];

  tsp_bbox_tracker u_bbox (
    .aclk    (aclk),
    .aresetn (aresetn),
    .init    (w_start_ok),
    .update  (rd_en & (r_state == LOAD)),
    .city    (w_city),
    .min_x   (min_x),
    .max_x   (max_x),
    .min_y   (min_y),
    .max_y   (max_y)
  );
`endif

endmodule
`default_nettype wire

// File: doc/tsp_city_loader.md
Name: tsp_city_loader

Overview:
Downstream consumer of the AXI read stage's FWFT output FIFO. Pops 64-bit city words, unpacks each into X/Y coordinates and writes them into the local city RAM. Pulses load_done back to the read stage when the requested city count has been stored. Then drains the read stage's zero-padding words until the read stage signals odone, so that stage always reaches its terminal state.

Parameters:
C_DATA_WIDTH, 64, FIFO word width; must equal 2*C_COORD_WIDTH
C_COORD_WIDTH, 32, width of one coordinate; X = rd_data[C_COORD_WIDTH-1:0], Y = upper half
C_MAX_CITIES, 128, city RAM depth; equals the read stage's padded word count
C_CNT_WIDTH, 8, width of city counters; must hold C_MAX_CITIES

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load; ignored unless state is IDLE or DONE
num_cities  in  C_CNT_WIDTH  cities to load; sampled on start
rd_en  out  1  FIFO pop; combinational, = ~rd_tvalid_n & (state==LOAD | state==DRAIN)
rd_data  in  C_DATA_WIDTH  FIFO head data (FWFT)
rd_tvalid_n  in  1  FIFO empty; head invalid when high
src_odone  in  1  read stage padding-complete pulse
load_done  out  1  level to read stage; high from SIGNAL until next start
mem_we  out  1  registered RAM write enable
mem_addr  out  $clog2(C_MAX_CITIES)  registered RAM address
mem_wx  out  C_COORD_WIDTH  registered X write data
mem_wy  out  C_COORD_WIDTH  registered Y write data
city_count  out  C_CNT_WIDTH  cities written so far
busy  out  1  high in LOAD, SIGNAL, DRAIN
done  out  1  one-cycle pulse on entry to DONE
err  out  1  sticky until next start; set when num_cities is 0 or exceeds C_MAX_CITIES

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- FSM states:
  - IDLE: wait for start.
  - LOAD: pop and write cities.
  - SIGNAL: one cycle; assert load_done.
  - DRAIN: pop and discard padding words.
  - DONE: terminal until next start.
- Transitions:
  - IDLE/DONE -> LOAD on start. Latch target = min(num_cities, C_MAX_CITIES). Clear city_count. Set err per the rule above.
  - On start with num_cities == 0: target 0, err=1, go directly to SIGNAL.
  - LOAD -> SIGNAL on the pop where city_count+1 == target.
  - SIGNAL -> DRAIN unconditionally.
  - DRAIN -> DONE on src_odone. A pop and src_odone in the same cycle are both honoured.
- Write pipeline: each pop in LOAD registers mem_we=1, mem_addr=city_count, mem_wx and mem_wy. Latency is one cycle from pop to RAM write. city_count increments in that same cycle. mem_we is 0 in every other cycle.
- Pops in DRAIN never write the RAM.
- Stalls: rd_tvalid_n high means no pop and state holds; there is no timeout.
- A start received while busy is ignored.
- Counter widths: compare with C_CNT_WIDTH+1 bits so that target==C_MAX_CITIES (128) does not wrap. mem_addr takes the low bits of city_count.
- Asynchronous reset mid-load returns to IDLE immediately. RAM contents are undefined after that.

Optional Feature:
TSP_LOADER_BBOX_EN
- Defined: adds outputs min_x, max_x, min_y, max_y (C_COORD_WIDTH, unsigned), registered.
  - Initialised on start to all-ones minima and zero maxima.
  - Updated on each LOAD pop; padding words are excluded.
  - Valid when done pulses.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package tsp_pkg holds:
  - FSM state enum: IDLE, LOAD, SIGNAL, DRAIN, DONE.
  - C_COORD_WIDTH, C_MAX_CITIES, C_CNT_WIDTH.
  - city_t struct {x, y}.
- One sub-module, tsp_bbox_tracker, holds the min/max registers. It is instantiated only under TSP_LOADER_BBOX_EN.

Test Plan:
1. num_cities=5, FIFO preloaded with 128 words (5 real, 123 zeros), src_odone pulsed after the 128th pop:
   - 5 RAM writes at addr 0..4 with correct X/Y.
   - load_done rises the cycle after the 5th pop.
   - 123 further pops with no writes; done pulse; city_count=5.
2. num_cities=128 with a full stream:
   - 128 writes, addr 127 last, no counter wrap.
   - SIGNAL entered after the 128th pop; DRAIN exits on src_odone with no further pops.
3. num_cities=3 with rd_tvalid_n toggling every other cycle:
   - One pop per valid cycle.
   - mem_we only the cycle after each pop; data order preserved.
4. num_cities=0 and num_cities=200:
   - 0: err=1, no writes, load_done asserted.
   - 200: clamps to 128 writes, err=1.
5. aresetn low during LOAD after 2 writes:
   - All outputs 0 and state IDLE asynchronously.
   - A new start with num_cities=4 loads cleanly.
6. With TSP_LOADER_BBOX_EN, cities (3,9), (7,1), (5,5):
   - min_x=3, max_x=7, min_y=1, max_y=9 at done.
   - Zero padding words do not alter the results.
